tick_counter_fsm: RTL and testbench

Run-controlled 4-bit modulo counter that consumes the one-cycle enable pulse produced by the rate divider and advances once per pulse. It has start/stop/load control, selectable count direction and a registered wrap flag. It also drives an active-low 7-segment digit. It sits directly downstream of the rate divider, between that divider's tick output and the board HEX display.

---
 rtl/tick_counter_pkg.sv | 34 +++
 rtl/tick_counter_fsm_seg7_decoder.sv | 31 +++
 rtl/tick_counter_fsm.sv | 100 ++++++++++
 tb/tb_tick_counter_fsm.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/tick_counter_pkg.sv
// Shared definitions for the tick counter block: FSM state encoding,
// active-low 7-segment digit patterns and the load clamp helper.
package tick_counter_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } state_e;

    // Segment order {g,f,e,d,c,b,a}, active low.
    localparam logic [6:0] SEG_0 = 7'b1000000;
    localparam logic [6:0] SEG_1 = 7'b1111001;
    localparam logic [6:0] SEG_2 = 7'b0100100;
    localparam logic [6:0] SEG_3 = 7'b0110000;
    localparam logic [6:0] SEG_4 = 7'b0011001;
    localparam logic [6:0] SEG_5 = 7'b0010010;
    localparam logic [6:0] SEG_6 = 7'b0000010;
    localparam logic [6:0] SEG_7 = 7'b1111000;
    localparam logic [6:0] SEG_8 = 7'b0000000;
    localparam logic [6:0] SEG_9 = 7'b0010000;
    localparam logic [6:0] SEG_A = 7'b0001000;
    localparam logic [6:0] SEG_B = 7'b0000011;
    localparam logic [6:0] SEG_C = 7'b1000110;
    localparam logic [6:0] SEG_D = 7'b0100001;
    localparam logic [6:0] SEG_E = 7'b0000110;
    localparam logic [6:0] SEG_F = 7'b0001110;

    function automatic logic [3:0] clamp_load(input logic [3:0] val,
                                              input logic [3:0] max_val);
        return (val > max_val) ? max_val : val;
    endfunction

endpackage

// File: rtl/tick_counter_fsm_seg7_decoder.sv
// Combinational hex digit decoder: 4-bit value to active-low {g,f,e,d,c,b,a}.
module seg7_decoder
    import tick_counter_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_0;
        unique case (value_i)
            4'h0: seg_o = SEG_0;
            4'h1: seg_o = SEG_1;
            4'h2: seg_o = SEG_2;
            4'h3: seg_o = SEG_3;
            4'h4: seg_o = SEG_4;
            4'h5: seg_o = SEG_5;
            4'h6: seg_o = SEG_6;
            4'h7: seg_o = SEG_7;
            4'h8: seg_o = SEG_8;
            4'h9: seg_o = SEG_9;
            4'hA: seg_o = SEG_A;
            4'hB: seg_o = SEG_B;
            4'hC: seg_o = SEG_C;
            4'hD: seg_o = SEG_D;
            4'hE: seg_o = SEG_E;
            4'hF: seg_o = SEG_F;
        endcase
    end

endmodule

// File: rtl/tick_counter_fsm.sv
// Run-controlled modulo (COUNT_MAX+1) counter advanced by divider ticks,
// with start/stop/load control, direction select, wrap pulse and HEX drive.
module tick_counter_fsm
    import tick_counter_pkg::*;
#(
    parameter int unsigned COUNT_MAX = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start,
    input  logic       stop,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dir,
    output logic [3:0] count,
    output logic       running,
    output logic       wrap,
    output logic [6:0] hex
);

    localparam logic [3:0] MAX_C = 4'(COUNT_MAX);

    state_e     state_q;
    logic [3:0] count_q;
    logic       running_q;
    logic       wrap_q;

    logic [3:0] step_count_d;
    logic       step_wrap_d;

    always_comb begin
        step_count_d = count_q;
        step_wrap_d  = 1'b0;
        if (dir) begin
            if (count_q == MAX_C) begin
                step_count_d = '0;
                step_wrap_d  = 1'b1;
            end else begin
                step_count_d = count_q + 4'd1;
            end
        end else begin
            if (count_q == '0) begin
                step_count_d = MAX_C;
                step_wrap_d  = 1'b1;
            end else begin
                step_count_d = count_q - 4'd1;
            end
        end
    end

    // Priority: reset > load > stop > start > tick; start/stop only act per state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            count_q   <= '0;
            running_q <= 1'b0;
            wrap_q    <= 1'b0;
        end else begin
            wrap_q <= 1'b0;
            if (load) begin
                count_q   <= clamp_load(load_val, MAX_C);
                state_q   <= IDLE;
                running_q <= 1'b0;
            end else begin
                case (state_q)
                    RUN: begin
                        if (stop) begin
                            state_q   <= PAUSE;
                            running_q <= 1'b0;
                        end else if (tick) begin
                            count_q <= step_count_d;
                            wrap_q  <= step_wrap_d;
                        end
                    end
                    IDLE, PAUSE: begin
                        if (start && !stop) begin
                            state_q   <= RUN;
                            running_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q   <= IDLE;
                        running_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    seg7_decoder u_seg7 (
        .value_i (count_q),
        .seg_o   (hex)
    );

    assign count   = count_q;
    assign running = running_q;
    assign wrap    = wrap_q;

endmodule

// File: tb/tb_tick_counter_fsm.sv
// Scoreboard bench for tick_counter_fsm: two instances (COUNT_MAX 15 and 9)
// share stimulus; an abstract model queues expected outputs, a monitor compares.
module tb_tick_counter_fsm;

    logic       clk = 1'b0;
    logic       reset, tick, start, stop, load, dir;
    logic [3:0] load_val;

    logic [3:0] count15, count9;
    logic       running15, running9, wrap15, wrap9;
    logic [6:0] hex15, hex9;

    always #5 clk = ~clk;

    tick_counter_fsm #(.COUNT_MAX(15)) dut15 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .load(load), .load_val(load_val), .dir(dir),
        .count(count15), .running(running15), .wrap(wrap15), .hex(hex15)
    );

    tick_counter_fsm #(.COUNT_MAX(9)) dut9 (
        .clk(clk), .reset(reset), .tick(tick), .start(start), .stop(stop),
        .load(load), .load_val(load_val), .dir(dir),
        .count(count9), .running(running9), .wrap(wrap9), .hex(hex9)
    );

    typedef struct {
        int c15; int r15; int w15; int h15;
        int c9;  int r9;  int w9;  int h9;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    int seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                         7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Model state: count value and whether the counter is running.
    int m15_cnt = 0, m9_cnt = 0;
    bit m15_run = 0, m9_run = 0;
    bit m15_wrap = 0, m9_wrap = 0;

    task automatic model_step(input int max, input bit rst, input bit ld, input int lv,
                              input bit stp, input bit stt, input bit tk, input bit up,
                              inout int cnt, inout bit run, output bit wr);
        wr = 0;
        if (rst) begin
            cnt = 0; run = 0;
        end else if (ld) begin
            cnt = (lv < max) ? lv : max;
            run = 0;
        end else if (stp) begin
            run = 0;
        end else if (stt && !run) begin
            run = 1;
        end else if (tk && run) begin
            if (up) begin
                cnt = (cnt + 1) % (max + 1);
                wr  = (cnt == 0);
            end else begin
                wr  = (cnt == 0);
                cnt = (cnt + max) % (max + 1);
            end
        end
    endtask

    task automatic drive(input bit rst, input bit ld, input int lv, input bit stp,
                         input bit stt, input bit tk, input bit up);
        exp_t e;
        reset = rst; load = ld; load_val = 4'(lv); stop = stp; start = stt;
        tick = tk; dir = up;
        model_step(15, rst, ld, lv, stp, stt, tk, up, m15_cnt, m15_run, m15_wrap);
        model_step(9,  rst, ld, lv, stp, stt, tk, up, m9_cnt,  m9_run,  m9_wrap);
        e.c15 = m15_cnt; e.r15 = int'(m15_run); e.w15 = int'(m15_wrap); e.h15 = seg_tab[m15_cnt];
        e.c9  = m9_cnt;  e.r9  = int'(m9_run);  e.w9  = int'(m9_wrap);  e.h9  = seg_tab[m9_cnt];
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int act, input int req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t: got %0h, expected %0h", name, $time, act, req);
        end
    endtask

    // Monitor: every cycle the DUT presents a new registered output.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #3;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("count15",   int'(count15),   e.c15);
                check("running15", int'(running15), e.r15);
                check("wrap15",    int'(wrap15),    e.w15);
                check("hex15",     int'(hex15),     e.h15);
                check("count9",    int'(count9),    e.c9);
                check("running9",  int'(running9),  e.r9);
                check("wrap9",     int'(wrap9),     e.w9);
                check("hex9",      int'(hex9),      e.h9);
            end
        end
    end

    initial begin
        int budget;
        // drive(rst, ld, lv, stp, stt, tk, up)
        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        for (int i = 0; i < 16; i++) drive(0, 0, 0, 0, 0, 1, 1);

        drive(0, 1, 9, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 10; i++) drive(0, 0, 0, 0, 0, 1, 0);

        drive(0, 1, 12, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1);

        drive(0, 1, 4, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0, 1, 1);
        drive(0, 0, 0, 0, 1, 1, 1);
        drive(0, 0, 0, 0, 0, 1, 1);

        drive(1, 0, 0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 1, 0, 1);
        drive(0, 1, 2, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(0, 1, 7, 0, 0, 1, 1);

        drive(0, 1, 10, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1, 0, 1);
        drive(0, 0, 0, 0, 0, 1, 1);
        drive(1, 0, 0, 0, 0, 1, 1);

        for (int i = 0; i < 3000; i++) begin
            drive(($urandom_range(63) == 0), ($urandom_range(31) == 0),
                  int'($urandom_range(15)), ($urandom_range(15) == 0),
                  ($urandom_range(7) == 0), ($urandom_range(3) != 0),
                  bit'($urandom_range(1)));
        end
        drive(0, 0, 0, 0, 0, 0, 1);

        budget = 10;
        while (exp_q.size() > 0 && budget > 0) begin
            @(posedge clk);
            budget--;
        end
        #5;
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected responses never compared, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
